// File: rtl/turbo_pkt_dispatch.sv
// Round-robin packet dispatcher: locks one ready lane per fixed-length packet and
// forwards each accepted beat to that lane one cycle later.
module turbo_pkt_dispatch #(
  parameter int BUS       = 534,
  parameter int NUM_CH    = 16,
  parameter int PKT_BEATS = 25,
  parameter int SKIP_BUSY = 1,
  localparam int CHW      = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [BUS-1:0]    in_data,
  input  logic              in_en,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [BUS-1:0]    out_data,
  output logic [NUM_CH-1:0] out_en,
  output logic              out_sop,
  output logic              out_eop,
  output logic [CHW-1:0]    cur_ch,
  output logic              busy,
  output logic              err_drop
);

  localparam int BCW = ($clog2(PKT_BEATS) > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(PKT_BEATS - 1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);
  localparam logic [CHW:0]   NUM_CH_W  = (CHW + 1)'(NUM_CH);

  typedef enum logic {SEARCH, XFER} state_t;

  state_t             r_state, w_state_next;
  logic               r_in_ready, w_in_ready_next;
  logic               r_busy, w_busy_next;
  logic [CHW-1:0]     r_cur_ch, w_cur_ch_next;
  logic [CHW-1:0]     r_rr_ptr, w_rr_ptr_next;
  logic [BCW-1:0]     r_beat_cnt, w_beat_cnt_next;
  logic [BUS-1:0]     r_out_data;
  logic [NUM_CH-1:0]  r_out_en;
  logic               r_out_sop, r_out_eop, r_err_drop;

  logic [CHW-1:0]     w_idx [NUM_CH];
  logic [NUM_CH-1:0]  w_rdy_rot;
  logic [NUM_CH-1:0]  w_lane_sel;
  logic               w_hit;
  logic [CHW-1:0]     w_sel;
  logic               w_accept;
  logic               w_last;

  // w_idx[gi] is the lane gi steps after rr_ptr, wrapped so it never reaches NUM_CH.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [CHW:0] w_sum;
    assign w_sum         = {1'b0, r_rr_ptr} + (CHW + 1)'(gi);
    assign w_idx[gi]     = (w_sum >= NUM_CH_W) ? CHW'(w_sum - NUM_CH_W) : w_sum[CHW-1:0];
    assign w_rdy_rot[gi] = ch_ready[w_idx[gi]];
    assign w_lane_sel[gi] = (r_cur_ch == CHW'(gi));
  end

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = r_rr_ptr;
    if (SKIP_BUSY != 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (w_rdy_rot[i]) begin
          w_hit = 1'b1;
          w_sel = w_idx[i];
        end
      end
    end else begin
      w_hit = w_rdy_rot[0];
    end
  end

  assign w_accept = in_en & r_in_ready;
  assign w_last   = (r_beat_cnt == LAST_BEAT);

  always_comb begin
    w_state_next    = r_state;
    w_in_ready_next = 1'b0;
    w_busy_next     = r_busy;
    w_cur_ch_next   = r_cur_ch;
    w_rr_ptr_next   = r_rr_ptr;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      SEARCH: begin
        if (w_hit) begin
          w_state_next    = XFER;
          w_cur_ch_next   = w_sel;
          w_busy_next     = 1'b1;
          w_in_ready_next = 1'b1;
        end
      end
      XFER: begin
        w_in_ready_next = ch_ready[r_cur_ch];
        if (w_accept) begin
          if (w_last) begin
            w_beat_cnt_next = '0;
            w_rr_ptr_next   = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + CHW'(1);
            w_state_next    = SEARCH;
            w_in_ready_next = 1'b0;
            w_busy_next     = 1'b0;
          end else begin
            w_beat_cnt_next = r_beat_cnt + BCW'(1);
          end
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_cur_ch   <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_out_data <= '0;
      r_out_en   <= '0;
      r_out_sop  <= 1'b0;
      r_out_eop  <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_next;
      r_busy     <= w_busy_next;
      r_cur_ch   <= w_cur_ch_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_out_en   <= w_accept ? w_lane_sel : '0;
      r_out_sop  <= w_accept && (r_beat_cnt == '0);
      r_out_eop  <= w_accept && w_last;
      r_err_drop <= in_en && !r_in_ready;
      if (w_accept) r_out_data <= in_data;
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign cur_ch   = r_cur_ch;
  assign out_data = r_out_data;
  assign out_en   = r_out_en;
  assign out_sop  = r_out_sop;
  assign out_eop  = r_out_eop;
  assign err_drop = r_err_drop;

endmodule

// File: tb/tb_turbo_pkt_dispatch.sv
// Directed bench for turbo_pkt_dispatch: three instances (4 lanes skip-busy,
// 4 lanes strict rotation, 5 lanes skip-busy) exercised one scenario at a time.
module tb_turbo_pkt_dispatch;
  localparam int BUS = 32;
  localparam int PB  = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [BUS-1:0] in_data = '0;
  logic           in_en_a = 1'b0, in_en_b = 1'b0, in_en_c = 1'b0;
  logic [3:0]     ch_ready_a = '1, ch_ready_b = '1;
  logic [4:0]     ch_ready_c = '1;

  logic           in_ready_a, in_ready_b, in_ready_c;
  logic [BUS-1:0] out_data_a, out_data_b, out_data_c;
  logic [3:0]     out_en_a, out_en_b;
  logic [4:0]     out_en_c;
  logic           sop_a, sop_b, sop_c, eop_a, eop_b, eop_c;
  logic [1:0]     cur_ch_a, cur_ch_b;
  logic [2:0]     cur_ch_c;
  logic           busy_a, busy_b, busy_c, err_a, err_b, err_c;

  turbo_pkt_dispatch #(.BUS(BUS), .NUM_CH(4), .PKT_BEATS(PB), .SKIP_BUSY(1)) u_a (
    .clk_bus(clk), .rst(rst), .in_data(in_data), .in_en(in_en_a), .in_ready(in_ready_a),
    .ch_ready(ch_ready_a), .out_data(out_data_a), .out_en(out_en_a), .out_sop(sop_a),
    .out_eop(eop_a), .cur_ch(cur_ch_a), .busy(busy_a), .err_drop(err_a));

  turbo_pkt_dispatch #(.BUS(BUS), .NUM_CH(4), .PKT_BEATS(PB), .SKIP_BUSY(0)) u_b (
    .clk_bus(clk), .rst(rst), .in_data(in_data), .in_en(in_en_b), .in_ready(in_ready_b),
    .ch_ready(ch_ready_b), .out_data(out_data_b), .out_en(out_en_b), .out_sop(sop_b),
    .out_eop(eop_b), .cur_ch(cur_ch_b), .busy(busy_b), .err_drop(err_b));

  turbo_pkt_dispatch #(.BUS(BUS), .NUM_CH(5), .PKT_BEATS(PB), .SKIP_BUSY(1)) u_c (
    .clk_bus(clk), .rst(rst), .in_data(in_data), .in_en(in_en_c), .in_ready(in_ready_c),
    .ch_ready(ch_ready_c), .out_data(out_data_c), .out_en(out_en_c), .out_sop(sop_c),
    .out_eop(eop_c), .cur_ch(cur_ch_c), .busy(busy_c), .err_drop(err_c));

  typedef struct {
    int lane;
    int nout;
    int lead_lows;
    int stall_lows;
    bit end_low;
    int flags_bad;
    int data_bad;
    int drops;
    int drops_seen;
    int err_bad;
    int extra;
    int max_cur;
    bit timeout;
  } res_t;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [BUS-1:0] gdata    = 32'h1000;

  function automatic logic [7:0] f_oe(input int d);
    case (d)
      0:       f_oe = {4'b0, out_en_a};
      1:       f_oe = {4'b0, out_en_b};
      default: f_oe = {3'b0, out_en_c};
    endcase
  endfunction
  function automatic logic f_rdy(input int d);
    f_rdy = (d == 0) ? in_ready_a : (d == 1) ? in_ready_b : in_ready_c;
  endfunction
  function automatic logic f_err(input int d);
    f_err = (d == 0) ? err_a : (d == 1) ? err_b : err_c;
  endfunction
  function automatic logic f_sop(input int d);
    f_sop = (d == 0) ? sop_a : (d == 1) ? sop_b : sop_c;
  endfunction
  function automatic logic f_eop(input int d);
    f_eop = (d == 0) ? eop_a : (d == 1) ? eop_b : eop_c;
  endfunction
  function automatic logic f_busy(input int d);
    f_busy = (d == 0) ? busy_a : (d == 1) ? busy_b : busy_c;
  endfunction
  function automatic int f_cur(input int d);
    f_cur = (d == 0) ? int'(cur_ch_a) : (d == 1) ? int'(cur_ch_b) : int'(cur_ch_c);
  endfunction
  function automatic logic [BUS-1:0] f_data(input int d);
    f_data = (d == 0) ? out_data_a : (d == 1) ? out_data_b : out_data_c;
  endfunction

  task automatic set_en(input int d, input logic v);
    case (d)
      0:       in_en_a = v;
      1:       in_en_b = v;
      default: in_en_c = v;
    endcase
  endtask
  task automatic set_ch(input int d, input int k, input logic v);
    case (d)
      0:       ch_ready_a[k] = v;
      1:       ch_ready_b[k] = v;
      default: ch_ready_c[k] = v;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_en_a = 1'b0; in_en_b = 1'b0; in_en_c = 1'b0;
    ch_ready_a = '1; ch_ready_b = '1; ch_ready_c = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one packet to instance d with in_en held high until 25 beats are
  // taken; records what the lane side saw. Optionally drops the locked lane's
  // ch_ready for stall_len cycles once stall_at beats have been offered.
  task automatic send_pkt(input int d, input int stall_at, input int stall_len,
                          input int budget, output res_t r);
    int             sent;
    int             cnt;
    int             ln;
    bit             prev_acc;
    bit             prev_drop;
    bit             rdy;
    logic [7:0]     oe;
    logic [BUS-1:0] exp_d;
    logic [BUS-1:0] q[$];
    r = '{default: 0};
    r.lane = -1;
    r.timeout = 1'b1;
    sent = 0; cnt = -1; prev_acc = 1'b0; prev_drop = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      oe  = f_oe(d);
      rdy = f_rdy(d);
      if (f_err(d) !== prev_drop) r.err_bad++;
      if (f_err(d) === 1'b1) r.drops_seen++;
      if (f_busy(d) === 1'b1 && f_cur(d) > r.max_cur) r.max_cur = f_cur(d);
      if (oe != 0) begin
        ln = -1;
        for (int i = 0; i < 8; i++) if (oe[i]) ln = i;
        if (!prev_acc || !$onehot(oe)) r.flags_bad++;
        if (r.nout == 0) r.lane = ln;
        else if (ln != r.lane) r.flags_bad++;
        if (f_sop(d) !== (r.nout == 0)) r.flags_bad++;
        if (f_eop(d) !== (r.nout == PB - 1)) r.flags_bad++;
        if (q.size() == 0) r.data_bad++;
        else begin
          exp_d = q.pop_front();
          if (f_data(d) !== exp_d) r.data_bad++;
        end
        r.nout++;
      end else if (prev_acc || f_sop(d) !== 1'b0 || f_eop(d) !== 1'b0) begin
        r.flags_bad++;
      end
      if (r.nout >= PB) begin
        r.end_low = !rdy;
        r.timeout = 1'b0;
        set_en(d, 1'b0);
        break;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) set_ch(d, r.lane, 1'b1);
      end
      if (stall_at >= 0 && cnt < 0 && sent == stall_at && r.lane >= 0) begin
        set_ch(d, r.lane, 1'b0);
        cnt = stall_len;
      end
      if (sent < PB && cyc < budget - 1) begin
        set_en(d, 1'b1);
        in_data = gdata;
        if (rdy) begin
          q.push_back(gdata);
          gdata++;
          sent++;
          prev_acc = 1'b1; prev_drop = 1'b0;
          if (cnt > 0) r.extra++;
        end else begin
          prev_acc = 1'b0; prev_drop = 1'b1;
          r.drops++;
          if (sent == 0) r.lead_lows++;
          else r.stall_lows++;
        end
      end else begin
        set_en(d, 1'b0);
        prev_acc = 1'b0; prev_drop = 1'b0;
      end
    end
    $display("pkt dut=%0d lane=%0d beats=%0d lead_lows=%0d stall_lows=%0d drops=%0d timeout=%0d",
             d, r.lane, r.nout, r.lead_lows, r.stall_lows, r.drops, r.timeout);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready_a, busy_a, err_a, sop_a, eop_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags_a: got %b expected 00000", {in_ready_a, busy_a, err_a, sop_a, eop_a});
    end
    n_checks++;
    if (out_en_a !== 4'b0 || cur_ch_a !== 2'd0 || out_data_a !== '0) begin
      n_fail++; $display("FAIL reset_out_a: out_en=%b cur_ch=%0d data=%h expected 0", out_en_a, cur_ch_a, out_data_a);
    end
    n_checks++;
    if (in_ready_b !== 1'b0 || busy_c !== 1'b0 || cur_ch_c !== 3'd0 || out_en_c !== 5'b0) begin
      n_fail++; $display("FAIL reset_bc: rdy_b=%b busy_c=%b cur_c=%0d oe_c=%b expected 0", in_ready_b, busy_c, cur_ch_c, out_en_c);
    end
    rst = 1'b0;
  endtask

  task automatic test_rr_all_ready();
    res_t r;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      send_pkt(0, -1, 0, 60, r);
      n_checks++;
      if (r.timeout || r.nout != PB || r.lane != p) begin
        n_fail++; $display("FAIL rr4_lane p%0d: lane=%0d beats=%0d expected lane %0d beats %0d", p, r.lane, r.nout, p, PB);
      end
      n_checks++;
      if (r.flags_bad != 0 || r.data_bad != 0 || r.err_bad != 0) begin
        n_fail++; $display("FAIL rr4_beats p%0d: flag_err=%0d data_err=%0d drop_err=%0d expected 0", p, r.flags_bad, r.data_bad, r.err_bad);
      end
      n_checks++;
      if (!r.end_low || r.lead_lows != 0) begin
        n_fail++; $display("FAIL rr4_gap p%0d: end_low=%0d lead_lows=%0d expected 1 and 0", p, r.end_low, r.lead_lows);
      end
    end
  endtask

  task automatic test_skip_busy();
    res_t r;
    do_reset();
    send_pkt(0, -1, 0, 60, r);
    send_pkt(0, -1, 0, 60, r);
    n_checks++;
    if (r.lane != 1) begin
      n_fail++; $display("FAIL skip_pre: lane=%0d expected 1", r.lane);
    end
    ch_ready_a = 4'b1011;
    send_pkt(0, -1, 0, 60, r);
    n_checks++;
    if (r.timeout || r.lane != 3 || r.nout != PB || r.flags_bad != 0) begin
      n_fail++; $display("FAIL skip_lane3: lane=%0d beats=%0d flag_err=%0d expected 3/25/0", r.lane, r.nout, r.flags_bad);
    end
    send_pkt(0, -1, 0, 60, r);
    n_checks++;
    if (r.timeout || r.lane != 0 || r.nout != PB) begin
      n_fail++; $display("FAIL skip_lane0: lane=%0d beats=%0d expected 0/25", r.lane, r.nout);
    end

    do_reset();
    send_pkt(1, -1, 0, 60, r);
    send_pkt(1, -1, 0, 60, r);
    ch_ready_b = 4'b1011;
    send_pkt(1, -1, 0, 12, r);
    n_checks++;
    if (!r.timeout || r.nout != 0 || r.lead_lows != 11) begin
      n_fail++; $display("FAIL strict_stall: timeout=%0d beats=%0d lows=%0d expected 1/0/11", r.timeout, r.nout, r.lead_lows);
    end
    n_checks++;
    if (r.drops_seen != 11 || r.err_bad != 0 || r.flags_bad != 0) begin
      n_fail++; $display("FAIL strict_drop: pulses=%0d drop_err=%0d flag_err=%0d expected 11/0/0", r.drops_seen, r.err_bad, r.flags_bad);
    end
    ch_ready_b[2] = 1'b1;
    send_pkt(1, -1, 0, 60, r);
    n_checks++;
    if (r.timeout || r.lane != 2 || r.nout != PB || r.data_bad != 0) begin
      n_fail++; $display("FAIL strict_release: lane=%0d beats=%0d data_err=%0d expected 2/25/0", r.lane, r.nout, r.data_bad);
    end
  endtask

  task automatic test_mid_stall();
    res_t r;
    do_reset();
    send_pkt(0, 10, 5, 80, r);
    n_checks++;
    if (r.timeout || r.lane != 0 || r.nout != PB || r.flags_bad != 0 || r.data_bad != 0) begin
      n_fail++; $display("FAIL stall_pkt: lane=%0d beats=%0d flag_err=%0d data_err=%0d expected 0/25/0/0", r.lane, r.nout, r.flags_bad, r.data_bad);
    end
    n_checks++;
    if (r.stall_lows != 5 || r.extra != 1) begin
      n_fail++; $display("FAIL stall_ready: lows=%0d extra=%0d expected 5/1", r.stall_lows, r.extra);
    end
    n_checks++;
    if (r.drops_seen != 5 || r.err_bad != 0) begin
      n_fail++; $display("FAIL stall_drop: pulses=%0d drop_err=%0d expected 5/0", r.drops_seen, r.err_bad);
    end
    send_pkt(0, -1, 0, 60, r);
    n_checks++;
    if (r.lane != 1 || r.nout != PB) begin
      n_fail++; $display("FAIL stall_next: lane=%0d beats=%0d expected 1/25", r.lane, r.nout);
    end
  endtask

  task automatic test_err_drop();
    res_t r;
    do_reset();
    ch_ready_a = 4'b0000;
    @(negedge clk);
    in_en_a = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    in_en_a = 1'b0;
    n_checks++;
    if (err_a !== 1'b1 || out_en_a !== 4'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL search_drop: err=%b out_en=%b busy=%b rdy=%b expected 1/0000/0/0", err_a, out_en_a, busy_a, in_ready_a);
    end
    @(negedge clk);
    n_checks++;
    if (err_a !== 1'b0 || out_en_a !== 4'b0) begin
      n_fail++; $display("FAIL search_drop_end: err=%b out_en=%b expected 0/0000", err_a, out_en_a);
    end
    ch_ready_a = 4'b1111;
    send_pkt(0, -1, 0, 60, r);
    n_checks++;
    if (r.lane != 0 || r.nout != PB || r.data_bad != 0 || r.flags_bad != 0) begin
      n_fail++; $display("FAIL drop_after: lane=%0d beats=%0d data_err=%0d flag_err=%0d expected 0/25/0/0", r.lane, r.nout, r.data_bad, r.flags_bad);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    do_reset();
    for (int p = 0; p < 12; p++) begin
      send_pkt(2, -1, 0, 60, r);
      n_checks++;
      if (r.timeout || r.lane != p % 5 || r.nout != PB || r.max_cur > 4 || r.flags_bad != 0) begin
        n_fail++; $display("FAIL rr5 p%0d: lane=%0d beats=%0d max_cur=%0d flag_err=%0d expected %0d/25/<=4/0",
                           p, r.lane, r.nout, r.max_cur, r.flags_bad, p % 5);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    res_t r;
    int   sent;
    do_reset();
    send_pkt(0, -1, 0, 60, r);
    sent = 0;
    for (int cyc = 0; cyc < 60 && sent < 12; cyc++) begin
      @(negedge clk);
      in_en_a = 1'b1;
      in_data = gdata;
      if (in_ready_a) begin
        sent++;
        gdata++;
      end
    end
    @(negedge clk);
    in_en_a = 1'b0;
    n_checks++;
    if (out_en_a !== 4'b0010 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst: out_en=%b busy=%b expected 0010/1", out_en_a, busy_a);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_en_a !== 4'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b0 || cur_ch_a !== 2'd0 ||
        out_data_a !== '0 || sop_a !== 1'b0 || eop_a !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: out_en=%b busy=%b rdy=%b cur=%0d data=%h expected all 0",
                         out_en_a, busy_a, in_ready_a, cur_ch_a, out_data_a);
    end
    @(negedge clk);
    rst = 1'b0;
    send_pkt(0, -1, 0, 60, r);
    n_checks++;
    if (r.timeout || r.lane != 0 || r.nout != PB || r.flags_bad != 0) begin
      n_fail++; $display("FAIL post_rst: lane=%0d beats=%0d flag_err=%0d expected 0/25/0", r.lane, r.nout, r.flags_bad);
    end
  endtask

  initial begin
    test_reset();
    test_rr_all_ready();
    test_skip_busy();
    test_mid_stall();
    test_err_drop();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
